fixed_16_capped_accum: RTL and testbench

//  Sequential saturating Q8.8 accumulator; the integrating counterpart of the capped difference stage.

---
 rtl/fixed_16_capped_accum.sv | 157 +++++++++++++++
 tb/tb_fixed_16_capped_accum.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_16_capped_accum.sv
// Saturating signed fixed-point accumulator.
// Loads a start value, sums num_terms signed deltas taken over a valid/ready
// input port, clamps every partial sum to the signed range, and offers the
// final sum on a valid/ready output port. Sticky flags record clamping.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. Ready and valid are decoded from the
// registered FSM state only, so there is no combinational path from any
// input to any output. Once out_valid is high, out_sum and the flags hold
// until out_ready is seen.
module fixed_16_capped_accum #(
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,   // informational: the arithmetic ignores the binary point
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] init_val,
   input  logic [CNT_W-1:0]  num_terms,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sum,
   output logic              overflow,
   output logic              underflow,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Signed rails of the result format.
   localparam logic [DATA_W-1:0] POS_RAIL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] NEG_RAIL = {1'b1, {(DATA_W-1){1'b0}}};

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  n_terms;
   logic              ovf_q;
   logic              unf_q;

   logic [DATA_W:0]   sum_ext;
   logic              pos_clip;
   logic              neg_clip;
   logic              beat;
   logic              last_beat;

   // Sign-extended sum; the top two bits disagree exactly when the true sum
   // leaves the signed range (01 = above the positive rail, 10 = below the
   // negative rail).
   always_comb begin
      sum_ext   = {acc[DATA_W-1], acc} + {in_data[DATA_W-1], in_data};
      pos_clip  = (sum_ext[DATA_W:DATA_W-1] == 2'b01);
      neg_clip  = (sum_ext[DATA_W:DATA_W-1] == 2'b10);
      beat      = (state == S_ACCUM) && in_valid;
      last_beat = (cnt == (n_terms - CNT_W'(1)));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. start is only looked at in IDLE; an empty run goes
   // straight to DONE so the start value is reported one cycle later.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (num_terms == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (beat && last_beat) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: load on start, accumulate with clamping on each accepted beat.
   // A clamped value becomes the base for the next beat, so a run can come
   // back off the rail while the sticky flag stays set. Everything holds in
   // DONE and IDLE, keeping the last result visible until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         n_terms <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc     <= init_val;
                  cnt     <= '0;
                  n_terms <= num_terms;
                  ovf_q   <= 1'b0;
                  unf_q   <= 1'b0;
               end
            end
            S_ACCUM: begin
               if (beat) begin
                  if (pos_clip) begin
                     acc   <= POS_RAIL;
                     ovf_q <= 1'b1;
                  end else if (neg_clip) begin
                     acc   <= NEG_RAIL;
                     unf_q <= 1'b1;
                  end else begin
                     acc   <= sum_ext[DATA_W-1:0];
                  end
                  // Leaves ACCUM at cnt == n_terms-1, so this never wraps.
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Port decode from the registered state and datapath registers.
   always_comb begin
      in_ready  = (state == S_ACCUM);
      out_valid = (state == S_DONE);
      busy      = (state != S_IDLE);
      out_sum   = acc;
      overflow  = ovf_q;
      underflow = unf_q;
      dbg_state = state;
   end

endmodule

// File: tb/tb_fixed_16_capped_accum.sv
// Directed bench for fixed_16_capped_accum. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_fixed_16_capped_accum;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] init_val;
   logic [7:0]  num_terms;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        overflow;
   logic        underflow;
   logic        busy;
   logic [1:0]  dbg_state;

   int checks;
   int errors;

   fixed_16_capped_accum #(
      .DATA_W   (16),
      .FRAC_BITS(8),
      .CNT_W    (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .init_val (init_val),
      .num_terms(num_terms),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .overflow (overflow),
      .underflow(underflow),
      .busy     (busy),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Called on a falling edge; returns on the falling edge after the start cycle.
   task automatic do_start(input logic [15:0] iv, input logic [7:0] n);
      start     = 1'b1;
      init_val  = iv;
      num_terms = n;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      init_val  = 16'h0000;
      num_terms = 8'h00;
   endtask

   // Presents one delta and waits (bounded) for it to transfer. Leaves
   // in_valid high so consecutive calls give back-to-back beats.
   task automatic send_beat(input logic [15:0] d);
      bit taken;
      taken    = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int w = 0; w < 20 && !taken; w++) begin
         if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
            taken = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (!taken) begin
         errors++;
         $display("FAIL beat_accept: got no transfer expected transfer of %h within 20 cycles", d);
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h0000) begin
         errors++;
         $display("FAIL reset_sum: got %h expected 0000", out_sum);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d expected 0", dbg_state);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_basic();
      do_start(16'h0100, 8'd3);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b101) begin
         errors++;
         $display("FAIL t1_accum_entry: got %b expected 101", {in_ready, out_valid, busy});
      end
      send_beat(16'h0080);
      send_beat(16'h0040);
      send_beat(16'hFFC0);
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01100) begin
         errors++;
         $display("FAIL t1_done_flags: got %b expected 01100",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h0180) begin
         errors++;
         $display("FAIL t1_sum: got %h expected 0180", out_sum);
      end
      take_result();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_sum !== 16'h0180) begin
         errors++;
         $display("FAIL t1_release: got flags %b sum %h expected 000 sum 0180",
                  {in_ready, out_valid, busy}, out_sum);
      end
   endtask

   task automatic test_overflow();
      do_start(16'h7F00, 8'd2);
      send_beat(16'h0200);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL t2_overflow_mid: got %b expected 1", overflow);
      end
      send_beat(16'hFE00);
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01110) begin
         errors++;
         $display("FAIL t2_done_flags: got %b expected 01110",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h7DFF) begin
         errors++;
         $display("FAIL t2_sum: got %h expected 7dff", out_sum);
      end
      take_result();
      checks++;
      if (overflow !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t2_flag_hold: got ovf=%b valid=%b expected ovf=1 valid=0", overflow, out_valid);
      end
   endtask

   task automatic test_underflow();
      do_start(16'h8100, 8'd1);
      send_beat(16'hFE00);
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01101) begin
         errors++;
         $display("FAIL t3_done_flags: got %b expected 01101",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h8000) begin
         errors++;
         $display("FAIL t3_sum: got %h expected 8000", out_sum);
      end
      take_result();
   endtask

   task automatic test_zero_terms();
      in_valid = 1'b1;
      in_data  = 16'h0100;
      do_start(16'h1234, 8'd0);
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01100) begin
         errors++;
         $display("FAIL t4_done_flags: got %b expected 01100",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h1234) begin
         errors++;
         $display("FAIL t4_sum: got %h expected 1234", out_sum);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_sum !== 16'h1234) begin
         errors++;
         $display("FAIL t4_no_beat: got ready=%b sum %h expected ready=0 sum 1234", in_ready, out_sum);
      end
      in_valid = 1'b0;
      take_result();
   endtask

   task automatic test_backpressure();
      logic [15:0] deltas [6];
      deltas[0] = 16'h0100;
      deltas[1] = 16'hFF00;
      deltas[2] = 16'h0020;
      deltas[3] = 16'h7000;
      deltas[4] = 16'h1000;
      deltas[5] = 16'hF000;
      // in_valid high during the start cycle must not count as a beat.
      in_valid = 1'b1;
      in_data  = 16'h0100;
      do_start(16'h0010, 8'd6);
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (i == 2) begin
            start     = 1'b1;
            init_val  = 16'h5555;
            num_terms = 8'd1;
            @(negedge clk);
            start     = 1'b0;
            init_val  = 16'h0000;
            num_terms = 8'h00;
         end
         send_beat(deltas[i]);
      end
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01110) begin
         errors++;
         $display("FAIL t5_done_flags: got %b expected 01110",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h6FFF) begin
         errors++;
         $display("FAIL t5_sum: got %h expected 6fff", out_sum);
      end
      for (int k = 0; k < 5; k++) begin
         start     = (k == 1);
         init_val  = 16'h5555;
         num_terms = 8'd1;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 16'h6FFF) begin
            errors++;
            $display("FAIL t5_hold_%0d: got valid=%b sum %h expected valid=1 sum 6fff", k, out_valid, out_sum);
         end
      end
      start     = 1'b0;
      init_val  = 16'h0000;
      num_terms = 8'h00;
      take_result();
      checks++;
      if ({out_valid, busy} !== 2'b00 || out_sum !== 16'h6FFF) begin
         errors++;
         $display("FAIL t5_release: got %b sum %h expected 00 sum 6fff", {out_valid, busy}, out_sum);
      end
   endtask

   task automatic test_async_reset();
      do_start(16'h7F00, 8'd4);
      send_beat(16'h0200);
      in_data = 16'h0100;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b00000) begin
         errors++;
         $display("FAIL t6_async_flags: got %b expected 00000",
                  {in_ready, out_valid, busy, overflow, underflow});
      end
      checks++;
      if (out_sum !== 16'h0000 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL t6_async_sum: got sum %h state %0d expected sum 0000 state 0", out_sum, dbg_state);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t6_no_partial: got valid=%b busy=%b expected 0 0", out_valid, busy);
      end
      do_start(16'h0200, 8'd2);
      send_beat(16'h0100);
      send_beat(16'h0100);
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01100 || out_sum !== 16'h0400) begin
         errors++;
         $display("FAIL t6_fresh_run: got %b sum %h expected 01100 sum 0400",
                  {in_ready, out_valid, busy, overflow, underflow}, out_sum);
      end
      take_result();
   endtask

   task automatic test_back_to_back_max();
      do_start(16'h0000, 8'd255);
      for (int i = 0; i < 254; i++) begin
         send_beat(16'h0001);
      end
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL max_not_early: got %b expected 10", {in_ready, out_valid});
      end
      send_beat(16'h0001);
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, overflow, underflow} !== 5'b01100 || out_sum !== 16'h00FF) begin
         errors++;
         $display("FAIL max_run: got %b sum %h expected 01100 sum 00ff",
                  {in_ready, out_valid, busy, overflow, underflow}, out_sum);
      end
      take_result();
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      checks    = 0;
      errors    = 0;
      start     = 1'b0;
      init_val  = 16'h0000;
      num_terms = 8'h00;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_zero_terms();
      test_backpressure();
      test_async_reset();
      test_back_to_back_max();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
